// File: rtl/knight_cmd_seq_pkg.sv
// Shared constants for the Knight command path: command words, headings,
// response bytes and the sequencer state encoding.
package knight_cmd_seq_pkg;

    localparam logic [15:0] CAL_GYRO  = 16'h2000;
    localparam logic [7:0]  HDG_NORTH = 8'h00;
    localparam logic [7:0]  HDG_WEST  = 8'h3F;
    localparam logic [7:0]  HDG_SOUTH = 8'h7F;
    localparam logic [7:0]  HDG_EAST  = 8'hBF;

    localparam logic [7:0]  ACK_POS   = 8'hA5;
    localparam logic [7:0]  ACK_NEG   = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_SNT,
        WAIT_RESP,
        FINISH,
        FAULT
    } seq_state_t;

    function automatic logic is_busy(input seq_state_t s);
        return (s == ISSUE) || (s == WAIT_SNT) || (s == WAIT_RESP);
    endfunction

endpackage

// File: rtl/knight_cmd_seq_cmd_fifo.sv
// Circular command FIFO with occupancy count and a synchronous flush.
// A write while full is still taken when a read frees a slot in the same cycle.
module cmd_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd,
    input  logic                       flush,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              rd_ok;
    logic              wr_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_ok   = rd && !empty;
    assign wr_ok   = wr && (!full || rd_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_ok) - CW'(rd_ok);
        end
    end

    // Storage is data only; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/knight_cmd_seq.sv
// Issues queued Knight commands to RemoteComm one at a time, waiting for
// the response byte of each before sending the next.
module knight_cmd_seq
    import knight_cmd_seq_pkg::*;
#(
    parameter int         DEPTH = 16,
    parameter int         TMO_W = 24,
    parameter logic [7:0] ACK   = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic [15:0]            wr_cmd,
    output logic                   full,
    output logic                   empty,
    input  logic                   start,
    input  logic                   abort,
    output logic [15:0]            cmd,
    output logic                   snd_cmd,
    input  logic                   cmd_snt,
    input  logic                   resp_rdy,
    input  logic [7:0]             resp,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [$clog2(DEPTH):0] err_idx,
    output logic [$clog2(DEPTH):0] ack_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [15:0]       head;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     issue_cnt;
    logic [TMO_W-1:0]  tmo;
    logic              tmo_last;
    logic              abort_pend;
    logic              abort_eff;
    logic              pop;
    logic              flush;
    logic              run_start;
    logic              done_now;
    logic              ack_hit;
    logic              fail;
    logic              tmo_load;
    logic [15:0]       cmd_p1;
    logic              vld_p1;

    cmd_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (16)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr),
        .wr_data (wr_cmd),
        .rd      (pop),
        .flush   (flush),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    assign busy      = is_busy(state);
    assign abort_eff = abort || abort_pend;
    assign tmo_last  = (tmo == TMO_W'(1));
    assign cmd       = cmd_p1;
    assign snd_cmd   = vld_p1;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        flush     = abort;
        run_start = 1'b0;
        done_now  = 1'b0;
        ack_hit   = 1'b0;
        fail      = 1'b0;
        tmo_load  = 1'b0;
        case (state)
            IDLE: begin
                // An abort in the same cycle wins over start.
                if (start && !abort) begin
                    if (!empty) begin
                        state_nxt = ISSUE;
                        run_start = 1'b1;
                    end else begin
                        done_now  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                pop       = (fifo_count != '0);
                state_nxt = WAIT_SNT;
            end
            WAIT_SNT: begin
                if (cmd_snt) begin
                    if (abort_eff) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT_RESP;
                        tmo_load  = 1'b1;
                    end
                end
            end
            WAIT_RESP: begin
                if (resp_rdy) begin
                    ack_hit = (resp == ACK);
                    if (abort_eff) begin
                        state_nxt = IDLE;
                    end else if (resp == ACK) begin
                        state_nxt = empty ? FINISH : ISSUE;
                    end else begin
                        state_nxt = FAULT;
                        fail      = 1'b1;
                    end
                end else if (tmo_last) begin
                    state_nxt = abort_eff ? IDLE : FAULT;
                    fail      = !abort_eff;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
                done_now  = 1'b1;
            end
            FAULT: begin
                state_nxt = IDLE;
                flush     = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stage p1: command word and send strobe registered out of ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            cmd_p1 <= 16'h0000;
        end else begin
            vld_p1 <= (state == ISSUE);
            if (state == ISSUE) cmd_p1 <= head;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done       <= 1'b0;
            err        <= 1'b0;
            err_idx    <= '0;
            ack_cnt    <= '0;
            issue_cnt  <= '0;
            abort_pend <= 1'b0;
            tmo        <= '0;
        end else begin
            if (run_start) begin
                done      <= 1'b0;
                err       <= 1'b0;
                err_idx   <= '0;
                ack_cnt   <= '0;
                issue_cnt <= '0;
            end
            if (done_now)        done      <= 1'b1;
            if (state == FAULT)  err       <= 1'b1;
            if (ack_hit)         ack_cnt   <= ack_cnt + CW'(1);
            if (state == ISSUE)  issue_cnt <= issue_cnt + CW'(1);
            // issue_cnt already counts the failing command, hence the -1.
            if (fail)            err_idx   <= issue_cnt - CW'(1);

            if (state_nxt == IDLE)              abort_pend <= 1'b0;
            else if (abort && is_busy(state))   abort_pend <= 1'b1;

            if (tmo_load)                tmo <= '1;
            else if (state == WAIT_RESP) tmo <= tmo - TMO_W'(1);
        end
    end

endmodule

// File: tb/tb_knight_cmd_seq.sv
// Directed bench for knight_cmd_seq: a table of command runs plus
// hand-written sequences for latency, timeout, full queue and abort.
module tb_knight_cmd_seq;
    import knight_cmd_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0, start = 1'b0, abort = 1'b0;
    logic        cmd_snt = 1'b0, resp_rdy = 1'b0;
    logic [15:0] wr_cmd = '0;
    logic [7:0]  resp = '0;
    logic        full, empty, snd_cmd, busy, done, err;
    logic [15:0] cmd;
    logic [4:0]  err_idx, ack_cnt;

    knight_cmd_seq #(.DEPTH(16), .TMO_W(8), .ACK(8'hA5)) dut (
        .clk(clk), .rst(rst), .wr(wr), .wr_cmd(wr_cmd), .full(full), .empty(empty),
        .start(start), .abort(abort), .cmd(cmd), .snd_cmd(snd_cmd), .cmd_snt(cmd_snt),
        .resp_rdy(resp_rdy), .resp(resp), .busy(busy), .done(done), .err(err),
        .err_idx(err_idx), .ack_cnt(ack_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       n;
        logic [3:0][15:0] c;
        logic [3:0][7:0]  r;
        logic [4:0]       strobes;
        logic             done;
        logic             err;
        logic [4:0]       idx;
        logic [4:0]       ack;
    } vec_t;

    vec_t        tv [6];
    int          n_vec = 0;
    int          n_bad = 0;
    int          strobes;
    int          resp_idx;
    logic [15:0] cmd_log [32];
    logic [7:0]  resp_tbl [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        @(negedge clk);
        wr = 1'b1;
        wr_cmd = w;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        wr = 1'b0;
        start = 1'b1;
    endtask

    task automatic wait_strobe(input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            start = 1'b0;
            wr = 1'b0;
            if (snd_cmd) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: no snd_cmd within 20 cycles", name);
        end
    endtask

    // RemoteComm model: cmd_snt 2 cycles after each strobe, response 3 later.
    task automatic serve(input int budget);
        int snt_at, resp_at;
        bit fin;
        snt_at = -1; resp_at = -1; fin = 1'b0; strobes = 0;
        for (int c = 0; c < budget && !fin; c++) begin
            @(negedge clk);
            start = 1'b0; wr = 1'b0; abort = 1'b0; cmd_snt = 1'b0; resp_rdy = 1'b0;
            if (snd_cmd) begin
                if (strobes < 32) cmd_log[strobes] = cmd;
                strobes++;
                snt_at = c + 2;
            end
            if (c == snt_at) begin
                cmd_snt = 1'b1;
                resp_at = c + 3;
            end
            if (c == resp_at) begin
                resp_rdy = 1'b1;
                resp = (resp_idx < 32) ? resp_tbl[resp_idx] : ACK_POS;
                resp_idx++;
            end
            if (resp_at >= 0 && c > resp_at && c > snt_at && !busy) fin = 1'b1;
        end
        if (!fin) begin
            n_vec++;
            n_bad++;
            $display("FAIL serve_timeout: run not finished within %0d cycles", budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic all_ack();
        for (int i = 0; i < 32; i++) resp_tbl[i] = ACK_POS;
        resp_idx = 0;
    endtask

    initial begin
        int k;
        tv[0] = '{n: 3'd1, c: {16'h0, 16'h0, 16'h0, CAL_GYRO}, r: {8'h0, 8'h0, 8'h0, 8'hA5},
                  strobes: 5'd1, done: 1'b1, err: 1'b0, idx: 5'd0, ack: 5'd1};
        tv[1] = '{n: 3'd2, c: {16'h0, 16'h0, 16'h4002, 16'h43F3}, r: {8'h0, 8'h0, 8'hA5, 8'hA5},
                  strobes: 5'd2, done: 1'b1, err: 1'b0, idx: 5'd0, ack: 5'd2};
        tv[2] = '{n: 3'd3, c: {16'h0, 16'h4200, 16'h4100, 16'h4000}, r: {8'h0, 8'hA5, 8'h5A, 8'hA5},
                  strobes: 5'd2, done: 1'b0, err: 1'b1, idx: 5'd1, ack: 5'd1};
        tv[3] = '{n: 3'd1, c: {16'h0, 16'h0, 16'h0, 16'h4BF1}, r: {8'h0, 8'h0, 8'h0, 8'h00},
                  strobes: 5'd1, done: 1'b0, err: 1'b1, idx: 5'd0, ack: 5'd0};
        tv[4] = '{n: 3'd4, c: {16'h4004, 16'h4003, 16'h4002, 16'h4001}, r: {8'hA5, 8'hA5, 8'hA5, 8'hA5},
                  strobes: 5'd4, done: 1'b1, err: 1'b0, idx: 5'd0, ack: 5'd4};
        tv[5] = '{n: 3'd2, c: {16'h0, 16'h0, 16'h4302, 16'h4301}, r: {8'h0, 8'h0, 8'hA5, 8'h5A},
                  strobes: 5'd1, done: 1'b0, err: 1'b1, idx: 5'd0, ack: 5'd0};

        // Reset values
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_snd_cmd", snd_cmd, 0);
        check("rst_cmd", cmd, 16'h0000);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_err_idx", err_idx, 0);
        check("rst_ack_cnt", ack_cnt, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);

        // start in cycle N gives snd_cmd in cycle N+2
        push(CAL_GYRO);
        pulse_start();
        @(negedge clk); start = 1'b0;
        check("lat_n1_snd", snd_cmd, 0);
        @(negedge clk);
        check("lat_n2_snd", snd_cmd, 1);
        check("lat_n2_cmd", cmd, CAL_GYRO);
        @(negedge clk);
        check("lat_n3_snd", snd_cmd, 0);
        check("lat_n3_cmd_held", cmd, CAL_GYRO);
        cmd_snt = 1'b1;
        @(negedge clk); cmd_snt = 1'b0;
        @(negedge clk); resp_rdy = 1'b1; resp = ACK_POS;
        @(negedge clk); resp_rdy = 1'b0;
        @(negedge clk);
        check("lat_done", done, 1);
        check("lat_ack_cnt", ack_cnt, 1);
        check("lat_busy", busy, 0);

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 32; j++) resp_tbl[j] = (j < 4) ? tv[i].r[j] : ACK_POS;
            resp_idx = 0;
            for (int j = 0; j < int'(tv[i].n); j++) push(tv[i].c[j]);
            pulse_start();
            serve(200);
            check($sformatf("v%0d_strobes", i), strobes, tv[i].strobes);
            check($sformatf("v%0d_done", i), done, tv[i].done);
            check($sformatf("v%0d_err", i), err, tv[i].err);
            check($sformatf("v%0d_err_idx", i), err_idx, tv[i].idx);
            check($sformatf("v%0d_ack_cnt", i), ack_cnt, tv[i].ack);
            check($sformatf("v%0d_empty", i), empty, 1);
            check($sformatf("v%0d_busy", i), busy, 0);
            for (int j = 0; j < int'(tv[i].strobes); j++)
                check($sformatf("v%0d_cmd%0d", i, j), cmd_log[j], tv[i].c[j]);
        end

        // start on an empty queue sets done at once and leaves err alone
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("empty_start_done", done, 1);
        check("empty_start_err", err, 1);
        check("empty_start_busy", busy, 0);

        // Response timeout: fault decided 255 cycles after cmd_snt
        push(16'h4222);
        pulse_start();
        wait_strobe("tmo_strobe");
        @(negedge clk); cmd_snt = 1'b1;
        @(negedge clk); cmd_snt = 1'b0;
        repeat (254) @(negedge clk);
        check("tmo_busy_255", busy, 1);
        @(negedge clk);
        check("tmo_err_256", err, 0);
        @(negedge clk);
        check("tmo_err_257", err, 1);
        check("tmo_err_idx", err_idx, 0);
        check("tmo_done", done, 0);

        // DEPTH+1 pushes: last one dropped
        for (int i = 0; i < 17; i++) push(16'h5000 + 16'(i));
        @(negedge clk); wr = 1'b0;
        check("full_full", full, 1);
        check("full_empty", empty, 0);
        all_ack();
        pulse_start();
        serve(400);
        check("full_strobes", strobes, 16);
        check("full_first_cmd", cmd_log[0], 16'h5000);
        check("full_last_cmd", cmd_log[15], 16'h500F);
        check("full_ack_cnt", ack_cnt, 16);
        check("full_done", done, 1);

        // Push while full in the same cycle as the first pop is accepted
        for (int i = 0; i < 16; i++) push(16'h6100 + 16'(i));
        all_ack();
        pulse_start();
        @(negedge clk); start = 1'b0; wr = 1'b1; wr_cmd = 16'h6FFF;
        serve(400);
        check("fullpop_strobes", strobes, 17);
        check("fullpop_last_cmd", cmd_log[16], 16'h6FFF);
        check("fullpop_ack_cnt", ack_cnt, 17);

        // abort in WAIT_RESP of the first of four commands
        for (int i = 0; i < 4; i++) push(16'h7001 + 16'(i));
        pulse_start();
        wait_strobe("abort_strobe");
        check("abort_first_cmd", cmd, 16'h7001);
        @(negedge clk);
        @(negedge clk); cmd_snt = 1'b1;
        @(negedge clk); cmd_snt = 1'b0;
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("abort_flushed", empty, 1);
        check("abort_still_busy", busy, 1);
        resp_rdy = 1'b1; resp = ACK_POS;
        @(negedge clk); resp_rdy = 1'b0;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (snd_cmd) k++;
        end
        check("abort_no_strobe", k, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_err", err, 0);
        check("abort_empty", empty, 1);

        // cmd_snt and resp_rdy together in WAIT_SNT: response not consumed
        push(CAL_GYRO);
        pulse_start();
        wait_strobe("same_strobe");
        @(negedge clk); cmd_snt = 1'b1; resp_rdy = 1'b1; resp = ACK_POS;
        @(negedge clk); cmd_snt = 1'b0; resp_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check("same_busy", busy, 1);
        check("same_ack_cnt", ack_cnt, 0);
        check("same_done", done, 0);
        resp_rdy = 1'b1; resp = ACK_POS;
        @(negedge clk); resp_rdy = 1'b0;
        @(negedge clk);
        check("same_done_after", done, 1);
        check("same_ack_after", ack_cnt, 1);

        // Reset mid-run abandons the command and clears the queue
        push(16'h4111);
        push(16'h4112);
        pulse_start();
        wait_strobe("midrst_strobe");
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_snd", snd_cmd, 0);
        check("midrst_cmd", cmd, 16'h0000);
        check("midrst_empty", empty, 1);
        check("midrst_done", done, 0);
        check("midrst_ack", ack_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
